// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared word type and depth constants for the Hack memory hierarchy.
package hack_mem_pkg;
    localparam int DATA_W       = 16;
    localparam int RAM8_DEPTH   = 8;
    localparam int RAM64_DEPTH  = 64;
    localparam int RAM512_DEPTH = 512;
    localparam int RAM4K_DEPTH  = 4096;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/ram_512.sv
// ram_512: 512-word register bank, combinational read, synchronous write, async active-low clear.
module ram_512
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  word_t             in,
    input  logic [ADDR_W-1:0] address,
    input  logic              clock,
    input  logic              load,
    output word_t             out,
    input  logic              reset_n
);
    word_t r_mem [2**ADDR_W];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
        end else if (load) begin
            r_mem[address] <= in;
        end
    end

    assign out = r_mem[address];
endmodule

// File: rtl/ram_4k.sv
// ram_4k: 4096 x 16 memory built from eight ram_512 banks selected by the top address bits.
module ram_4k
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int BANK_W = 3
) (
    input  word_t             in,
    input  logic [ADDR_W-1:0] address,
    input  logic              clock,
    input  logic              load,
    output word_t             out,
    input  logic              reset_n
);
    localparam int BANKS = 2**BANK_W;
    localparam int SUB_W = ADDR_W - BANK_W;

    logic [BANK_W-1:0] w_bank_sel;
    logic [SUB_W-1:0]  w_sub_addr;
    logic [BANKS-1:0]  w_bank_load;
    word_t             w_bank_out [BANKS];

    assign w_bank_sel = address[ADDR_W-1 -: BANK_W];
    assign w_sub_addr = address[SUB_W-1:0];

    genvar k;
    generate
        for (k = 0; k < BANKS; k++) begin : g_bank
            assign w_bank_load[k] = load && (w_bank_sel == BANK_W'(k));
            ram_512 #(.ADDR_W(SUB_W)) u_bank (
                .in      (in),
                .address (w_sub_addr),
                .clock   (clock),
                .load    (w_bank_load[k]),
                .out     (w_bank_out[k]),
                .reset_n (reset_n)
            );
        end
    endgenerate

    assign out = w_bank_out[w_bank_sel];
endmodule

// File: tb/tb_ram_4k.sv
// tb_ram_4k: directed and random stimulus against an array model; a queue-based monitor checks reads.
`timescale 1ns/1ps
module tb_ram_4k;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [11:0] address = '0;
    logic [15:0] in = '0;
    logic [15:0] out;
    logic        rd_v = 1'b0;

    logic [15:0] model [4096];
    logic [11:0] exp_a [$];
    logic [15:0] exp_d [$];
    int          n_total = 0;
    int          n_pass = 0;

    ram_4k dut (
        .in      (in),
        .address (address),
        .clock   (clock),
        .load    (load),
        .out     (out),
        .reset_n (reset_n)
    );

    always #1 clock = ~clock;

    // monitor: every marked cycle the DUT read is compared with the oldest expectation
    always @(negedge clock) begin
        if (rd_v) begin
            n_total++;
            if (exp_d.size() == 0) begin
                $display("FAIL rd@%0d: got %h, no expected value queued", address, out);
            end else begin
                logic [11:0] a;
                logic [15:0] d;
                a = exp_a.pop_front();
                d = exp_d.pop_front();
                if (out === d && address === a) n_pass++;
                else $display("FAIL rd@%0d: got %h, want %h (addr %0d)", a, out, d, address);
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 4096; i++) model[i] = '0;
    endtask

    // one cycle: drive inputs, optionally queue the expected read (pre-write value)
    task automatic op(input bit ld, input logic [11:0] a, input logic [15:0] d, input bit chk);
        @(posedge clock);
        #0.5;
        load = ld;
        address = a;
        in = d;
        rd_v = chk;
        if (chk) begin
            exp_a.push_back(a);
            exp_d.push_back(model[a]);
        end
        if (ld && reset_n) model[a] = d;
    endtask

    initial begin
        logic [11:0] pool [8];
        clear_model();
        #3.3 reset_n = 1'b1;
        // reset state sweep over powers of two and the last word
        op(0, 12'd0, 16'h0, 1);
        for (int i = 0; i < 12; i++) op(0, 12'(1 << i), 16'h0, 1);
        op(0, 12'd4095, 16'h0, 1);
        // write 15 at 1024, then read neighbourhood
        op(1, 12'd1024, 16'd15, 1);
        op(0, 12'd0, 16'h0, 1);
        for (int i = 0; i < 12; i++) op(0, 12'(1 << i), 16'h0, 1);
        op(0, 12'd4095, 16'h0, 1);
        // hold: in ignored while load=0
        for (int i = 0; i < 4; i++) op(0, 12'd1024, 16'hFFFF, 1);
        // bank boundaries
        op(1, 12'd511, 16'hA5A5, 1);
        op(1, 12'd512, 16'h5A5A, 1);
        op(0, 12'd511, 16'h0, 1);
        op(0, 12'd512, 16'h0, 1);
        op(0, 12'd510, 16'h0, 1);
        op(0, 12'd513, 16'h0, 1);
        // randomized mix over a small address pool so reads hit written words
        for (int i = 0; i < 8; i++) pool[i] = 12'($urandom_range(0, 4095));
        pool[0] = 12'd4095;
        pool[1] = 12'd0;
        for (int i = 0; i < 300; i++) begin
            logic [11:0] a;
            a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : pool[$urandom_range(0, 7)];
            op(1'($urandom_range(0, 2) == 0), a, 16'($urandom), 1);
        end
        // async reset between edges: out drops before the next clock edge
        op(1, 12'd1024, 16'd15, 0);
        op(0, 12'd1024, 16'h0, 1);
        @(posedge clock);
        #0.3;
        reset_n = 1'b0;
        clear_model();
        load = 1'b0;
        address = 12'd1024;
        rd_v = 1'b1;
        exp_a.push_back(12'd1024);
        exp_d.push_back(16'h0);
        // load edge while in reset writes nothing
        op(1, 12'd1024, 16'h1234, 1);
        op(1, 12'd7, 16'h4321, 1);
        op(0, 12'd1024, 16'h0, 0);
        reset_n = 1'b1;
        op(0, 12'd1024, 16'h0, 1);
        op(0, 12'd7, 16'h0, 1);
        op(0, 12'd4095, 16'h0, 1);
        op(1, 12'd4095, 16'hBEEF, 1);
        op(0, 12'd4095, 16'h0, 1);
        @(posedge clock);
        #0.5;
        rd_v = 1'b0;
        for (int i = 0; i < 10 && exp_d.size() != 0; i++) @(posedge clock);
        if (exp_d.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, want 0", exp_d.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
